// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift_serdes engine.
package shift_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions for port and counter sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_serdes_bit_prescaler.sv
// Bit-period down-counter: loads a start value and reloads at zero while enabled.
module bit_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic [DIV_W-1:0] reload_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload_val : cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/shift_serdes.sv
// Full-duplex parametrised shift engine: parallel load, serial TX/RX, parallel RX word.
module shift_serdes
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  input  logic [DIV_W-1:0] div,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic             eos,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shreg, shreg_nxt;
  logic               dir;
  logic [DIV_W-1:0]   period;
  logic [CNT_W-1:0]   bitcnt;
  logic               tick;
  logic               accept;
  logic               last;

  assign load_ready = (state == S_IDLE);
  assign busy       = (state == S_SHIFT);
  assign accept     = (state == S_IDLE) && load_valid;
  assign last       = tick && (bitcnt == CNT_W'(WIDTH - 1));

  bit_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_val   (div),
    .reload_val (period),
    .en         (busy),
    .tick       (tick)
  );

  // TX and RX share one register: the outgoing edge empties as sin fills the other end.
  always_comb begin
    shreg_nxt = shreg;
    if (dir) shreg_nxt = {shreg[WIDTH-2:0], sin};
    else     shreg_nxt = {sin, shreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (last)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      dir        <= 1'b0;
      period     <= '0;
      bitcnt     <= '0;
      sout       <= 1'b0;
      eos        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      eos        <= 1'b0;
      dout_valid <= 1'b0;
      if (accept) begin
        shreg  <= din;
        dir    <= msb_first;
        period <= div;
        bitcnt <= '0;
        sout   <= msb_first ? din[WIDTH-1] : din[0];
      end else if (busy && tick) begin
        shreg  <= shreg_nxt;
        bitcnt <= bitcnt + CNT_W'(1);
        if (last) begin
          sout       <= 1'b0;
          eos        <= 1'b1;
          dout_valid <= 1'b1;
          dout       <= shreg_nxt;
        end else begin
          sout <= dir ? shreg[WIDTH-2] : shreg[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_serdes.sv
// Directed self-checking bench for shift_serdes (WIDTH=8, DIV_W=8).
module tb_shift_serdes;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       load_valid;
  logic       load_ready;
  logic       msb_first;
  logic [7:0] div;
  logic       sin;
  logic       sout;
  logic       busy;
  logic       eos;
  logic [7:0] dout;
  logic       dout_valid;

  logic loop_en;
  logic sin_drv;
  assign sin = loop_en ? sout : sin_drv;

  int total;
  int bad;
  int eos_cnt;
  int cyc;

  shift_serdes #(
    .WIDTH (8),
    .DIV_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .msb_first  (msb_first),
    .div        (div),
    .sin        (sin),
    .sout       (sout),
    .busy       (busy),
    .eos        (eos),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eos) eos_cnt <= eos_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;
    int c1;
    int c2;
    int ecnt;
    total = 0; bad = 0; eos_cnt = 0; cyc = 0;
    rst_n = 1'b1; din = '0; load_valid = 1'b0; msb_first = 1'b1; div = '0;
    loop_en = 1'b0; sin_drv = 1'b0;

    // 1: asynchronous reset asserted between edges
    #13 rst_n = 1'b0;
    #1;
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sout", sout, 0);
    chk("rst_eos", eos, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dout_valid, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();

    // 2: MSB-first, div=0, loopback A5
    w = 8'hA5; din = w; msb_first = 1'b1; div = 8'd0; loop_en = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_ready", load_ready, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t2_sout", sout, w[7-i]);
      chk("t2_no_eos", eos, 0);
      step();
    end
    chk("t2_eos", eos, 1);
    chk("t2_dvalid", dout_valid, 1);
    chk("t2_dout", dout, 8'hA5);
    chk("t2_idle", busy, 0);
    chk("t2_sout0", sout, 0);
    step();
    chk("t2_eos_pulse", eos, 0);
    chk("t2_dv_pulse", dout_valid, 0);

    // 3: LSB-first, div=2, loopback 81
    w = 8'h81; din = w; msb_first = 1'b0; div = 8'd2; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("t3_sout", sout, w[i/3]);
      chk("t3_busy", busy, 1);
      step();
    end
    chk("t3_eos", eos, 1);
    chk("t3_busy_end", busy, 0);
    chk("t3_dout", dout, 8'h81);

    // 4: zero word, sin held 1, div=1, ignored mid-shift load
    loop_en = 1'b0; sin_drv = 1'b1;
    din = 8'h00; msb_first = 1'b1; div = 8'd1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t4_sout", sout, 0);
      if (i == 5) begin
        load_valid = 1'b1; din = 8'h5A; div = 8'd0; msb_first = 1'b0;
        chk("t4_ready_busy", load_ready, 0);
      end else begin
        load_valid = 1'b0;
      end
      step();
    end
    chk("t4_eos", eos, 1);
    chk("t4_dout", dout, 8'hFF);
    step();
    chk("t4_no_restart", busy, 0);
    chk("t4_no_eos", eos, 0);

    // 5: back-to-back, load_valid held, div=0, loopback
    loop_en = 1'b1; din = 8'h3C; msb_first = 1'b1; div = 8'd0; load_valid = 1'b1;
    step();
    repeat (8) step();
    chk("t5_eos1", eos, 1);
    chk("t5_dout1", dout, 8'h3C);
    chk("t5_gap_sout", sout, 0);
    chk("t5_gap_ready", load_ready, 1);
    c1 = cyc;
    din = 8'hC3;
    step();
    load_valid = 1'b0;
    chk("t5_accept2", busy, 1);
    chk("t5_first_bit", sout, 1);
    repeat (7) step();
    chk("t5_not_yet", eos, 0);
    step();
    c2 = cyc;
    chk("t5_eos2", eos, 1);
    chk("t5_dout2", dout, 8'hC3);
    chk("t5_spacing", c2 - c1, 9);

    // 6: reset mid-word, then a clean word
    din = 8'hFF; msb_first = 1'b1; div = 8'd3; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (12) step();
    chk("t6_busy_pre", busy, 1);
    ecnt = eos_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 0);
    chk("t6_sout_rst", sout, 0);
    chk("t6_ready_rst", load_ready, 1);
    chk("t6_dout_rst", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    chk("t6_no_eos", eos_cnt, ecnt);
    din = 8'h0F; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (31) step();
    chk("t6_busy_last", busy, 1);
    chk("t6_eos_early", eos, 0);
    step();
    chk("t6_eos", eos, 1);
    chk("t6_dout", dout, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim ran past limit");
    $fatal(1);
  end

endmodule
